cache_arbiter: RTL and testbench
================================

# cache_arbiter

Shares the single cacheline-wide memory port between the instruction cache and the data cache. Each cache connects its line-fill/writeback port (addr, read, write, 256-bit wdata/rdata, resp) as a requester. The arbiter grants one requester at a time with round-robin fairness and holds the grant until the downstream memory responds. It sits between the two `cache` instances and the burst/cacheline adapter in front of DRAM.

## Interface
- `ADDR_WIDTH`, 32, address width on every port
- `LINE_WIDTH`, 256, cacheline width on every data bus
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  reset; asynchronous, active-high
- `i_addr`  in  ADDR_WIDTH  icache line address, 32-byte aligned
- `i_read`  in  1  icache line read request
- `i_write`  in  1  icache line write request (tied 0 in practice, still arbitrated)
- `i_wdata`  in  LINE_WIDTH  icache write line
- `i_rdata`  out  LINE_WIDTH  read line to icache
- `i_resp`  out  1  completion strobe to icache
- `d_addr`, `d_read`, `d_write`, `d_wdata`, `d_rdata`, `d_resp`: same as the `i_*` ports, for the dcache
- `dfp_addr`  out  ADDR_WIDTH  downstream address
- `dfp_read`  out  1  downstream read
- `dfp_write`  out  1  downstream write
- `dfp_wdata`  out  LINE_WIDTH  downstream write line
- `dfp_rdata`  in  LINE_WIDTH  downstream read line
- `dfp_resp`  in  1  downstream completion, one cycle per transaction
- `busy`  out  1  high in any SERVE state

## Operation
- A requester is pending when `read|write` is high. Requesters hold their request stable until their `resp`. Asserting `read` and `write` together is illegal; the arbiter forwards both unchanged and does not check.
- Grant policy: if only one requester is pending, it wins. If both are pending, the one not served last wins. The last-served pointer `last_d` resets to 0, so the dcache wins the first tie.
- States: ARB_IDLE, ARB_SERVE_I, ARB_SERVE_D.
  - ARB_IDLE: evaluate pending requests. Next state is the winner's SERVE state, or stay in ARB_IDLE if nothing is pending.
  - ARB_SERVE_x: `dfp_addr/read/write/wdata` are a combinational pass-through of requester x's inputs. All other `dfp_*` outputs are 0.
  - ARB_SERVE_x on `dfp_resp`: `x_resp` = 1 in the same cycle. At the next edge, update `last_d` and go to ARB_IDLE.
- `i_rdata` and `d_rdata` are both driven with `dfp_rdata` at all times. Only `resp` is gated by the grant.
- The grant is never revoked before `dfp_resp`. If requester x drops its request mid-transaction, `dfp_read/write` follow it low, but the state stays in ARB_SERVE_x until `dfp_resp`.
- `dfp_resp` arriving in ARB_IDLE is ignored: no `resp` on either port, no state change.
- A dcache writeback followed by its allocate read is two separate transactions. The icache may be granted between them; this is legal.

## Timing
- Reset (async assert): state = ARB_IDLE, `last_d` = 0. All outputs are 0: `dfp_*`, `i_resp`, `d_resp`, `busy`. `*_rdata` mirror `dfp_rdata`.
- Request first seen in ARB_IDLE at cycle t: `dfp_read/write` asserted at t+1.
- `dfp_resp` at cycle r: `x_resp` at r (combinational). ARB_IDLE at r+1. A new grant can drive `dfp_*` at r+2 at the earliest.
- Minimum of one idle cycle between back-to-back downstream transactions.
- Reset asserted mid-transaction: immediate return to ARB_IDLE, and any in-flight `dfp_resp` is dropped. The downstream must be reset together with the arbiter.
- No combinational path from `dfp_resp` to `dfp_*` outputs, or from any request input to `*_resp`.

## Structure
- Package `arbiter_pkg`:
  - `typedef enum logic [1:0] arb_state_t {ARB_IDLE, ARB_SERVE_I, ARB_SERVE_D}`
  - `localparam LINE_WIDTH = 256`
  - `localparam ADDR_WIDTH = 32`
- Single module. The 2-way round-robin pick is a few lines of comb logic and does not need a sub-module.
- Two flops of state: the FSM and `last_d`.

## Test plan
- Icache alone reads 0x0000_1000; downstream responds 3 cycles after `dfp_read` with line 0xAA..AA. Required: `dfp_addr` = 0x1000 one cycle after the request, `i_resp` pulses once with `i_rdata` = 0xAA..AA, `d_resp` stays 0.
- Both request in the same cycle after reset (I read 0x2000, D write 0x3000). Required: D is served first with `dfp_write`=1 and `dfp_addr`=0x3000, then one idle cycle, then I is served with `dfp_read`=1 and `dfp_addr`=0x2000.
- Both requesting continuously for 6 transactions. Required: grants alternate D, I, D, I, D, I, with exactly one ARB_IDLE cycle between each.
- Dcache writeback to 0x4000 then allocate read of 0x8000, while the icache is pending. Required: write, then I read, then D read; every line is returned intact.
- `rst` pulsed while in ARB_SERVE_I with `dfp_read` high. Required: all outputs 0 immediately. After release, a D-only request is granted normally.
- Spurious `dfp_resp` in ARB_IDLE. Required: no `resp` on either port, and state stays ARB_IDLE.

Source files
------------

// File: rtl/arbiter_pkg.sv
// Shared types and widths for the cache-to-memory arbiter.
package arbiter_pkg;

    localparam int LINE_WIDTH = 256;
    localparam int ADDR_WIDTH = 32;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_SERVE_I = 2'd1,
        ARB_SERVE_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/cache_arbiter_if.sv
// Signal bundle between the two caches, the arbiter and the downstream
// cacheline adapter.
//
// Handshake: a requester is pending while read|write is high and holds
// addr/read/write/wdata stable until it sees a one-cycle resp. rdata is
// valid in the cycle resp is high. Downstream raises dfp_resp for exactly
// one cycle per transaction; the arbiter never drops a grant before it.
interface cache_arbiter_if
    import arbiter_pkg::*;
#(
    parameter int AW = ADDR_WIDTH,
    parameter int LW = LINE_WIDTH
);
    // icache requester
    logic [AW-1:0] i_addr;
    logic          i_read;
    logic          i_write;
    logic [LW-1:0] i_wdata;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    // dcache requester
    logic [AW-1:0] d_addr;
    logic          d_read;
    logic          d_write;
    logic [LW-1:0] d_wdata;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    // downstream memory port
    logic [AW-1:0] dfp_addr;
    logic          dfp_read;
    logic          dfp_write;
    logic [LW-1:0] dfp_wdata;
    logic [LW-1:0] dfp_rdata;
    logic          dfp_resp;

    // Arbiter view.
    modport slave (
        input  i_addr, i_read, i_write, i_wdata,
        output i_rdata, i_resp,
        input  d_addr, d_read, d_write, d_wdata,
        output d_rdata, d_resp,
        output dfp_addr, dfp_read, dfp_write, dfp_wdata,
        input  dfp_rdata, dfp_resp
    );

    // Environment view: caches plus downstream memory.
    modport master (
        output i_addr, i_read, i_write, i_wdata,
        input  i_rdata, i_resp,
        output d_addr, d_read, d_write, d_wdata,
        input  d_rdata, d_resp,
        input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
        output dfp_rdata, dfp_resp
    );
endinterface

// File: rtl/cache_arbiter.sv
// Two-way round-robin arbiter sharing one cacheline memory port between
// the icache and dcache. The grant is held until the downstream responds.
module cache_arbiter
    import arbiter_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    cache_arbiter_if.slave  bus,
    output logic            busy,
    output arb_state_t      state_dbg
);

    arb_state_t state_q;
    arb_state_t state_d;
    logic       last_d;     // 1 when the dcache was the most recently served

    logic pend_i;
    logic pend_d;

    assign pend_i = bus.i_read | bus.i_write;
    assign pend_d = bus.d_read | bus.d_write;

    // Read data goes to both caches unconditionally; only resp is steered.
    assign bus.i_rdata = bus.dfp_rdata;
    assign bus.d_rdata = bus.dfp_rdata;

    assign state_dbg = state_q;

    // State register plus the round-robin pointer, updated on completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            last_d  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (bus.dfp_resp && (state_q == ARB_SERVE_I)) begin
                last_d <= 1'b0;
            end else if (bus.dfp_resp && (state_q == ARB_SERVE_D)) begin
                last_d <= 1'b1;
            end
        end
    end

    // Next state: pick a winner in idle, leave a serve state only on resp.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: begin
                if (pend_i && pend_d) begin
                    // Tie goes to whoever was not served last.
                    state_d = last_d ? ARB_SERVE_I : ARB_SERVE_D;
                end else if (pend_d) begin
                    state_d = ARB_SERVE_D;
                end else if (pend_i) begin
                    state_d = ARB_SERVE_I;
                end
            end
            ARB_SERVE_I: begin
                if (bus.dfp_resp) state_d = ARB_IDLE;
            end
            ARB_SERVE_D: begin
                if (bus.dfp_resp) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Outputs: pass the granted requester through; steer resp to it only.
    always_comb begin
        bus.dfp_addr  = '0;
        bus.dfp_read  = 1'b0;
        bus.dfp_write = 1'b0;
        bus.dfp_wdata = '0;
        bus.i_resp    = 1'b0;
        bus.d_resp    = 1'b0;
        busy          = 1'b0;
        case (state_q)
            ARB_SERVE_I: begin
                bus.dfp_addr  = bus.i_addr;
                bus.dfp_read  = bus.i_read;
                bus.dfp_write = bus.i_write;
                bus.dfp_wdata = bus.i_wdata;
                bus.i_resp    = bus.dfp_resp;
                busy          = 1'b1;
            end
            ARB_SERVE_D: begin
                bus.dfp_addr  = bus.d_addr;
                bus.dfp_read  = bus.d_read;
                bus.dfp_write = bus.d_write;
                bus.dfp_wdata = bus.d_wdata;
                bus.d_resp    = bus.dfp_resp;
                busy          = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: the bench plays both caches and the
// downstream memory, with expected values written out by hand.
module tb_cache_arbiter;
    import arbiter_pkg::*;

    logic       clk;
    logic       rst;
    logic       busy;
    arb_state_t state_dbg;

    cache_arbiter_if bus ();

    cache_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [255:0] line_aa;
    logic [255:0] line_w1;
    logic [255:0] line_w2;
    logic [255:0] line_r1;
    logic [255:0] line_r2;
    logic [255:0] line_r3;

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; land 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Downstream completes the current transaction this cycle.
    task automatic mem_resp(input logic [255:0] data);
        bus.dfp_resp  = 1'b1;
        bus.dfp_rdata = data;
        #1;
    endtask

    initial begin
        line_aa = {32{8'hAA}};
        line_w1 = {8{32'hDEADBEEF}};
        line_w2 = {8{32'h0BADF00D}};
        line_r1 = {8{32'h11112222}};
        line_r2 = {8{32'h33334444}};
        line_r3 = {8{32'h55556666}};

        rst           = 1'b1;
        bus.i_addr    = '0;
        bus.i_read    = 1'b0;
        bus.i_write   = 1'b0;
        bus.i_wdata   = '0;
        bus.d_addr    = '0;
        bus.d_read    = 1'b0;
        bus.d_write   = 1'b0;
        bus.d_wdata   = '0;
        bus.dfp_rdata = line_r3;
        bus.dfp_resp  = 1'b0;

        // ---- reset state
        #2;
        chk("rst_state", state_dbg, ARB_IDLE);
        chk("rst_busy", busy, 1'b0);
        chk("rst_dfp_read", bus.dfp_read, 1'b0);
        chk("rst_dfp_write", bus.dfp_write, 1'b0);
        chk("rst_dfp_addr", bus.dfp_addr, 0);
        chk("rst_i_rdata_mirror", bus.i_rdata, line_r3);
        chk("rst_d_rdata_mirror", bus.d_rdata, line_r3);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // ---- icache alone reads 0x1000
        bus.i_addr = 32'h0000_1000;
        bus.i_read = 1'b1;
        #1;
        chk("t1_idle_no_read", bus.dfp_read, 1'b0);
        tick();
        chk("t1_state", state_dbg, ARB_SERVE_I);
        chk("t1_dfp_read", bus.dfp_read, 1'b1);
        chk("t1_dfp_addr", bus.dfp_addr, 32'h0000_1000);
        chk("t1_busy", busy, 1'b1);
        tick();
        tick();
        tick();
        chk("t1_no_early_resp", bus.i_resp, 1'b0);
        mem_resp(line_aa);
        chk("t1_i_resp", bus.i_resp, 1'b1);
        chk("t1_i_rdata", bus.i_rdata, line_aa);
        chk("t1_d_resp", bus.d_resp, 1'b0);
        tick();
        bus.dfp_resp = 1'b0;
        bus.i_read   = 1'b0;
        #1;
        chk("t1_back_idle", state_dbg, ARB_IDLE);
        chk("t1_i_resp_once", bus.i_resp, 1'b0);
        chk("t1_busy_low", busy, 1'b0);

        // ---- simultaneous requests: dcache wins the tie
        bus.i_addr  = 32'h0000_2000;
        bus.i_read  = 1'b1;
        bus.d_addr  = 32'h0000_3000;
        bus.d_write = 1'b1;
        bus.d_wdata = line_w1;
        tick();
        chk("t2_state_d", state_dbg, ARB_SERVE_D);
        chk("t2_dfp_write", bus.dfp_write, 1'b1);
        chk("t2_dfp_read", bus.dfp_read, 1'b0);
        chk("t2_dfp_addr", bus.dfp_addr, 32'h0000_3000);
        chk("t2_dfp_wdata", bus.dfp_wdata, line_w1);
        mem_resp(line_r3);
        chk("t2_d_resp", bus.d_resp, 1'b1);
        chk("t2_i_resp", bus.i_resp, 1'b0);
        tick();
        bus.dfp_resp = 1'b0;
        bus.d_write  = 1'b0;
        #1;
        chk("t2_gap_idle", state_dbg, ARB_IDLE);
        chk("t2_gap_dfp_read", bus.dfp_read, 1'b0);
        tick();
        chk("t2_state_i", state_dbg, ARB_SERVE_I);
        chk("t2_i_dfp_read", bus.dfp_read, 1'b1);
        chk("t2_i_dfp_addr", bus.dfp_addr, 32'h0000_2000);
        mem_resp(line_r1);
        chk("t2_i_resp2", bus.i_resp, 1'b1);
        chk("t2_i_rdata", bus.i_rdata, line_r1);
        tick();
        bus.dfp_resp = 1'b0;
        bus.i_read   = 1'b0;
        #1;

        // ---- both requesting continuously: D, I, D, I, D, I
        bus.i_addr = 32'h0000_A000;
        bus.i_read = 1'b1;
        bus.d_addr = 32'h0000_B000;
        bus.d_read = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k % 2 == 0) begin
                chk($sformatf("t3_grant%0d_d", k), state_dbg, ARB_SERVE_D);
                chk($sformatf("t3_addr%0d", k), bus.dfp_addr, 32'h0000_B000);
            end else begin
                chk($sformatf("t3_grant%0d_i", k), state_dbg, ARB_SERVE_I);
                chk($sformatf("t3_addr%0d", k), bus.dfp_addr, 32'h0000_A000);
            end
            mem_resp(line_r2);
            chk($sformatf("t3_d_resp%0d", k), bus.d_resp, (k % 2 == 0) ? 1'b1 : 1'b0);
            chk($sformatf("t3_i_resp%0d", k), bus.i_resp, (k % 2 == 1) ? 1'b1 : 1'b0);
            tick();
            bus.dfp_resp = 1'b0;
            #1;
            chk($sformatf("t3_gap%0d", k), state_dbg, ARB_IDLE);
        end
        bus.i_read = 1'b0;
        bus.d_read = 1'b0;
        tick();
        chk("t3_quiet", state_dbg, ARB_IDLE);

        // ---- dcache writeback then allocate, icache pending in between
        bus.d_addr  = 32'h0000_4000;
        bus.d_write = 1'b1;
        bus.d_wdata = line_w2;
        bus.i_addr  = 32'h0000_5000;
        bus.i_read  = 1'b1;
        tick();
        chk("t4_wb_state", state_dbg, ARB_SERVE_D);
        chk("t4_wb_write", bus.dfp_write, 1'b1);
        chk("t4_wb_addr", bus.dfp_addr, 32'h0000_4000);
        chk("t4_wb_wdata", bus.dfp_wdata, line_w2);
        mem_resp(line_r3);
        chk("t4_wb_resp", bus.d_resp, 1'b1);
        tick();
        bus.dfp_resp = 1'b0;
        bus.d_write  = 1'b0;
        bus.d_read   = 1'b1;
        bus.d_addr   = 32'h0000_8000;
        tick();
        chk("t4_i_between", state_dbg, ARB_SERVE_I);
        chk("t4_i_addr", bus.dfp_addr, 32'h0000_5000);
        chk("t4_i_read", bus.dfp_read, 1'b1);
        mem_resp(line_r1);
        chk("t4_i_resp", bus.i_resp, 1'b1);
        chk("t4_i_rdata", bus.i_rdata, line_r1);
        chk("t4_d_wait", bus.d_resp, 1'b0);
        tick();
        bus.dfp_resp = 1'b0;
        bus.i_read   = 1'b0;
        tick();
        chk("t4_alloc_state", state_dbg, ARB_SERVE_D);
        chk("t4_alloc_addr", bus.dfp_addr, 32'h0000_8000);
        chk("t4_alloc_read", bus.dfp_read, 1'b1);
        mem_resp(line_r2);
        chk("t4_alloc_resp", bus.d_resp, 1'b1);
        chk("t4_alloc_rdata", bus.d_rdata, line_r2);
        tick();
        bus.dfp_resp = 1'b0;
        bus.d_read   = 1'b0;
        #1;

        // ---- request dropped mid-grant, then reset while serving I
        bus.i_addr = 32'h0000_6000;
        bus.i_read = 1'b1;
        tick();
        chk("t5_state_i", state_dbg, ARB_SERVE_I);
        bus.i_read = 1'b0;
        #1;
        chk("t5_drop_read", bus.dfp_read, 1'b0);
        tick();
        chk("t5_grant_held", state_dbg, ARB_SERVE_I);
        chk("t5_busy_held", busy, 1'b1);
        bus.i_read = 1'b1;
        #1;
        chk("t5_read_again", bus.dfp_read, 1'b1);
        rst          = 1'b1;
        bus.dfp_resp = 1'b1;
        #1;
        chk("t5_rst_state", state_dbg, ARB_IDLE);
        chk("t5_rst_read", bus.dfp_read, 1'b0);
        chk("t5_rst_addr", bus.dfp_addr, 0);
        chk("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_i_resp", bus.i_resp, 1'b0);
        bus.i_read   = 1'b0;
        bus.dfp_resp = 1'b0;
        tick();
        rst = 1'b0;
        bus.d_addr = 32'h0000_7000;
        bus.d_read = 1'b1;
        tick();
        chk("t5_d_grant", state_dbg, ARB_SERVE_D);
        chk("t5_d_addr", bus.dfp_addr, 32'h0000_7000);
        mem_resp(line_r1);
        chk("t5_d_resp", bus.d_resp, 1'b1);
        tick();
        bus.dfp_resp = 1'b0;
        bus.d_read   = 1'b0;
        #1;

        // ---- spurious downstream resp while idle
        tick();
        bus.dfp_resp = 1'b1;
        #1;
        chk("t6_i_resp", bus.i_resp, 1'b0);
        chk("t6_d_resp", bus.d_resp, 1'b0);
        tick();
        bus.dfp_resp = 1'b0;
        chk("t6_state", state_dbg, ARB_IDLE);
        chk("t6_busy", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
